// File: rtl/dma_pkg.sv
// Shared types and defaults for the four-channel DMA request scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dma_pkg;

    localparam int DMA_NUM_CH = 4;
    localparam int DMA_CNT_W  = 8;

    typedef logic [1:0] ch_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2,
        ACK   = 2'd3
    } state_t;

    function automatic logic [DMA_NUM_CH-1:0] ch_onehot(input ch_idx_t ch);
        logic [DMA_NUM_CH-1:0] v;
        v = '0;
        v[ch] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational 4-way channel picker: fixed priority (ch0 first) or round robin from last_grant+1.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides when winner is consumed.
// Ports: elig (eligible channels), last_grant, rr_mode in; winner (index), any (some channel eligible) out.
module dma_rr_pick
    import dma_pkg::*;
(
    input  logic [DMA_NUM_CH-1:0] elig,
    input  ch_idx_t               last_grant,
    input  logic                  rr_mode,
    output ch_idx_t               winner,
    output logic                  any
);

    ch_idx_t start;
    ch_idx_t idx;

    always_comb begin
        winner = '0;
        idx    = '0;
        any    = |elig;
        start  = rr_mode ? ch_idx_t'(last_grant + 2'd1) : ch_idx_t'(2'd0);
        // Walk from the farthest offset down so the nearest eligible channel is written last and wins.
        for (int k = DMA_NUM_CH - 1; k >= 0; k--) begin
            idx = ch_idx_t'(start + ch_idx_t'(k));
            if (elig[idx]) begin
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/dma_ch_arbiter.sv
// Four-channel DMA request scheduler: arbitrates peripheral reqs, hands one channel to the AHB engine, acks it.
// Latency: eligible req -> grant_vld next cycle; eng_done -> ack next cycle -> IDLE the cycle after.
// Backpressure: grant_vld holds with a stable grant_ch until eng_ready; no new grant while a transfer is open.
// Ports: req/ack peripheral handshake; ch_en, rr_mode, cfg_* control; grant_*/eng_* engine side;
//        ch_active/ch_done/ch_err status with done_clr W1C; irq = any sticky flag.
module dma_ch_arbiter
    import dma_pkg::*;
#(
    parameter int NUM_CH = DMA_NUM_CH,
    parameter int CNT_W  = DMA_CNT_W
) (
    input  logic              hclk,
    input  logic              hreset_n,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] ack,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              rr_mode,
    input  logic              cfg_wr,
    input  logic [1:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_cnt,
    output logic              grant_vld,
    output logic [1:0]        grant_ch,
    input  logic              eng_ready,
    input  logic              eng_done,
    input  logic              eng_err,
    output logic [NUM_CH-1:0] ch_active,
    output logic [NUM_CH-1:0] ch_done,
    output logic [NUM_CH-1:0] ch_err,
    input  logic [NUM_CH-1:0] done_clr,
    output logic              irq
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state;
    ch_idx_t           last_grant;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] elig;
    logic [CNT_W-1:0]  cnt [NUM_CH];
    ch_idx_t           winner;
    logic              any;
    logic              cfg_hits_grant;
    logic              dec_evt;
    logic              err_evt;
    logic              done_evt;

    assign elig = req & ch_en & ch_active & ~mask;
    assign irq  = |(ch_done | ch_err);

    dma_rr_pick u_pick (
        .elig       (elig),
        .last_grant (last_grant),
        .rr_mode    (rr_mode),
        .winner     (winner),
        .any        (any)
    );

    // A same-cycle load on the granted channel overrides both the decrement and the done check.
    assign cfg_hits_grant = cfg_wr && (cfg_ch == grant_ch);
    assign err_evt  = (state == BUSY) && eng_err;
    // A channel cancelled by a zero load has cnt 0 already; skip the decrement so it cannot wrap.
    assign dec_evt  = (state == BUSY) && !eng_err && eng_done && (cnt[grant_ch] != '0) && !cfg_hits_grant;
    assign done_evt = (state == ACK) && ch_active[grant_ch] && (cnt[grant_ch] == '0) && !cfg_hits_grant;

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state      <= IDLE;
            grant_vld  <= 1'b0;
            grant_ch   <= '0;
            ack        <= '0;
            mask       <= '0;
            last_grant <= ch_idx_t'(2'd3);
        end else begin
            ack  <= '0;
            mask <= '0;
            case (state)
                IDLE: begin
                    if (any) begin
                        grant_ch  <= winner;
                        grant_vld <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (eng_ready) begin
                        grant_vld <= 1'b0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (eng_err) begin
                        state <= IDLE;
                    end else if (eng_done) begin
                        state      <= ACK;
                        ack        <= ch_onehot(grant_ch);
                        mask       <= ch_onehot(grant_ch);
                        last_grant <= grant_ch;
                    end
                end
                ACK: begin
                    // Keep the served channel masked one more cycle while its req falls.
                    state <= IDLE;
                    mask  <= ch_onehot(grant_ch);
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            ch_active <= '0;
            ch_done   <= '0;
            ch_err    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_wr && (cfg_ch == ch_idx_t'(i))) begin
                    cnt[i]       <= cfg_cnt;
                    ch_active[i] <= (cfg_cnt != '0);
                end else if (dec_evt && (grant_ch == ch_idx_t'(i))) begin
                    cnt[i] <= cnt[i] - CNT_ONE;
                end
                if ((err_evt || done_evt) && (grant_ch == ch_idx_t'(i))) begin
                    ch_active[i] <= 1'b0;
                end
                ch_done[i] <= (ch_done[i] & ~done_clr[i]) | (done_evt && (grant_ch == ch_idx_t'(i)));
                ch_err[i]  <= (ch_err[i] & ~done_clr[i]) | (err_evt && (grant_ch == ch_idx_t'(i)));
            end
        end
    end

endmodule

// File: tb/tb_dma_ch_arbiter.sv
module tb_dma_ch_arbiter;

    logic       hclk = 1'b0;
    logic       hreset_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] ack;
    logic [3:0] ch_en = '0;
    logic       rr_mode = 1'b0;
    logic       cfg_wr = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_cnt = '0;
    logic       grant_vld;
    logic [1:0] grant_ch;
    logic       eng_ready = 1'b1;
    logic       eng_done = 1'b0;
    logic       eng_err = 1'b0;
    logic [3:0] ch_active;
    logic [3:0] ch_done;
    logic [3:0] ch_err;
    logic [3:0] done_clr = '0;
    logic       irq;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    always #5 hclk = ~hclk;

    dma_ch_arbiter #(.NUM_CH(4), .CNT_W(8)) dut (
        .hclk      (hclk),
        .hreset_n  (hreset_n),
        .req       (req),
        .ack       (ack),
        .ch_en     (ch_en),
        .rr_mode   (rr_mode),
        .cfg_wr    (cfg_wr),
        .cfg_ch    (cfg_ch),
        .cfg_cnt   (cfg_cnt),
        .grant_vld (grant_vld),
        .grant_ch  (grant_ch),
        .eng_ready (eng_ready),
        .eng_done  (eng_done),
        .eng_err   (eng_err),
        .ch_active (ch_active),
        .ch_done   (ch_done),
        .ch_err    (ch_err),
        .done_clr  (done_clr),
        .irq       (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset();
        hreset_n = 1'b0;
        req = '0; cfg_wr = 1'b0; eng_done = 1'b0; eng_err = 1'b0; done_clr = '0;
        repeat (2) step();
        hreset_n = 1'b1;
        step();
    endtask

    task automatic cfg_load(input int ch, input logic [7:0] val);
        cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_cnt = val;
        step();
        cfg_wr = 1'b0;
    endtask

    // One served transfer: wait for a grant, compare against the scoreboard head, run the
    // engine for three cycles, then check the ack. cfg_at: 0 none, 1 load in first BUSY cycle,
    // 2 load together with eng_done.
    task automatic do_xfer(input bit err, input bit late_drop, input bit rearm,
                           input int cfg_at, input logic [7:0] cfg_val);
        bit got;
        int want_ch;
        int ch;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (grant_vld) got = 1'b1;
            else step();
        end
        if (!got) begin
            chk("grant_wait", 32'd0, 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            chk("unexpected_grant", 32'd1, 32'd0);
            return;
        end
        want_ch = exp_q.pop_front();
        ch = int'(grant_ch);
        chk("grant_ch", 32'(grant_ch), 32'(want_ch));
        step();
        if (cfg_at == 1) begin
            cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_cnt = cfg_val;
        end
        step();
        cfg_wr = 1'b0;
        step();
        if (err) eng_err = 1'b1;
        else eng_done = 1'b1;
        if (cfg_at == 2) begin
            cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_cnt = cfg_val;
        end
        step();
        eng_done = 1'b0; eng_err = 1'b0; cfg_wr = 1'b0;
        chk("ack", 32'(ack), err ? 32'd0 : (32'd1 << want_ch));
        if (!err) begin
            if (late_drop) begin
                step();
                chk("ack_pulse", 32'(ack), 32'd0);
            end
            req[ch] = 1'b0;
            step();
            if (!late_drop) chk("ack_pulse", 32'(ack), 32'd0);
            if (rearm) req[ch] = 1'b1;
        end else begin
            step();
        end
    endtask

    task automatic expect_no_grant(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (grant_vld) seen = 1'b1;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        // Reset state
        #12;
        chk("rst_grant_vld", 32'(grant_vld), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_flags", {20'd0, ch_active, ch_done, ch_err}, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        do_reset();

        // Fixed priority, ch0 only, nine transfers then done
        ch_en = 4'b0001; rr_mode = 1'b0;
        cfg_load(0, 8'd9);
        chk("ch0_active", 32'(ch_active), 32'h1);
        for (int n = 0; n < 9; n++) begin
            req[0] = 1'b1;
            exp_q.push_back(0);
            do_xfer(1'b0, 1'b0, 1'b0, 0, 8'd0);
            if (n == 7) chk("ch0_done_early", 32'(ch_done[0]), 32'd0);
        end
        chk("ch0_done", 32'(ch_done[0]), 32'd1);
        chk("ch0_irq", 32'(irq), 32'd1);
        chk("ch0_inactive", 32'(ch_active[0]), 32'd0);
        req[0] = 1'b1;
        expect_no_grant("ch0_tenth_req", 12);
        req[0] = 1'b0;

        // Round robin from reset, all requests held
        do_reset();
        ch_en = 4'b1111; rr_mode = 1'b1;
        for (int c = 0; c < 4; c++) cfg_load(c, 8'd16);
        req = 4'b1111;
        for (int n = 0; n < 8; n++) exp_q.push_back(n % 4);
        for (int n = 0; n < 8; n++) do_xfer(1'b0, 1'b0, 1'b1, 0, 8'd0);

        // Fixed priority, reqs still raised: ch0 first then ascending
        rr_mode = 1'b0;
        for (int n = 0; n < 4; n++) exp_q.push_back(n);
        for (int n = 0; n < 4; n++) do_xfer(1'b0, 1'b0, 1'b0, 0, 8'd0);
        chk("fp_req_clear", 32'(req), 32'd0);

        // Peripheral drops req one cycle late: single service only
        req[1] = 1'b1;
        exp_q.push_back(1);
        do_xfer(1'b0, 1'b1, 1'b0, 0, 8'd0);
        expect_no_grant("late_drop_no_regrant", 8);

        // Engine error on ch2
        req[2] = 1'b1;
        exp_q.push_back(2);
        do_xfer(1'b1, 1'b0, 1'b0, 0, 8'd0);
        chk("err_ch_err", 32'(ch_err), 32'h4);
        chk("err_ch_active", 32'(ch_active[2]), 32'd0);
        chk("err_irq", 32'(irq), 32'd1);
        req[2] = 1'b0;
        done_clr = 4'b0100;
        step();
        done_clr = 4'b0000;
        chk("clr_ch_err", 32'(ch_err), 32'd0);
        chk("clr_irq", 32'(irq), 32'd0);

        // Zero load on the busy channel cancels it but still acks
        req[1] = 1'b1;
        exp_q.push_back(1);
        do_xfer(1'b0, 1'b0, 1'b0, 1, 8'd0);
        chk("cancel_done", 32'(ch_done[1]), 32'd0);
        chk("cancel_active", 32'(ch_active[1]), 32'd0);

        // Load together with eng_done wins: ch1 then needs exactly five more transfers
        cfg_load(1, 8'd3);
        req[1] = 1'b1;
        exp_q.push_back(1);
        do_xfer(1'b0, 1'b0, 1'b0, 2, 8'd5);
        chk("load_wins_active", 32'(ch_active[1]), 32'd1);
        for (int n = 0; n < 5; n++) begin
            req[1] = 1'b1;
            exp_q.push_back(1);
            do_xfer(1'b0, 1'b0, 1'b0, 0, 8'd0);
            chk("load_wins_done", 32'(ch_done[1]), (n == 4) ? 32'd1 : 32'd0);
        end

        // Asynchronous reset while a grant is open
        done_clr = 4'b1111;
        step();
        done_clr = 4'b0000;
        eng_ready = 1'b0;
        req[0] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (grant_vld) got = 1'b1;
            else step();
        end
        chk("rst_mid_grant_seen", 32'(got), 32'd1);
        #2 hreset_n = 1'b0;
        #1;
        chk("arst_grant_vld", 32'(grant_vld), 32'd0);
        chk("arst_ack", 32'(ack), 32'd0);
        chk("arst_flags", {20'd0, ch_active, ch_done, ch_err}, 32'd0);
        chk("arst_irq", 32'(irq), 32'd0);
        #3 hreset_n = 1'b1;
        eng_ready = 1'b1;
        expect_no_grant("post_rst_no_grant", 10);
        cfg_load(0, 8'd1);
        exp_q.push_back(0);
        do_xfer(1'b0, 1'b0, 1'b0, 0, 8'd0);
        chk("post_rst_done", 32'(ch_done), 32'h1);
        chk("post_rst_irq", 32'(irq), 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
